rvc_fetch_aligner: RTL and testbench

Instruction fetch sequencer for the RV32EC multi-cycle core. It issues word-aligned 32-bit reads to instruction memory and buffers the returned halfword parcels. It presents one instruction at a time to the decode stage, either a 16-bit compressed instruction or a full 32-bit instruction, even when that instruction straddles a word boundary. It also tracks the instruction PC and handles control-flow redirects, including discarding data from an in-flight fetch.

---
 rtl/rvc_fetch_aligner_if.sv | 27 ++
 rtl/rvc_fetch_aligner.sv | 79 +++++++
 tb/tb_rvc_fetch_aligner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rvc_fetch_aligner_if.sv
// rvc_fetch_aligner_if: fetch-side memory bus, decode-side instruction bus and redirect bundle.
// Ports (master = aligner side):
//   MemReq/MemAddr out, MemAck/MemRdata in            -- word-aligned instruction memory reads
//   InstValid/InstData/InstCompressed/InstPc out,
//   InstReady in                                      -- one instruction per handshake to decode
//   Redirect/RedirectPc in                            -- control-flow restart
interface rvc_fetch_aligner_if;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic        InstValid;
    logic        InstReady;
    logic [31:0] InstData;
    logic        InstCompressed;
    logic [31:0] InstPc;
    logic        Redirect;
    logic [31:0] RedirectPc;
    modport master (
        output MemReq, MemAddr, InstValid, InstData, InstCompressed, InstPc,
        input  MemAck, MemRdata, InstReady, Redirect, RedirectPc
    );
    modport slave (
        input  MemReq, MemAddr, InstValid, InstData, InstCompressed, InstPc,
        output MemAck, MemRdata, InstReady, Redirect, RedirectPc
    );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: fetches aligned words, buffers halfword parcels and presents one RV32C/RV32 instruction at a time.
// Ports: Clock, Reset (async, active-high), bus (rvc_fetch_aligner_if.master).
// Parameter RESET_PC: PC of the first instruction after reset (bit 0 must be 0).
module rvc_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic Clock,
    input logic Reset,
    rvc_fetch_aligner_if.master bus
);
    logic [15:0] p [3];
    logic [15:0] q [3];
    logic [15:0] pNext [3];
    logic [15:0] first;
    logic [1:0]  cnt, cntPop, cntNext, popN;
    logic [31:0] fetchAddr, memAddr, instPc;
    logic        out, drop, skip;
    logic        lowOk, valid, ack, fill;

    always_comb begin
        lowOk = p[0][1:0] != 2'b11;
        valid = cnt != 2'd0 && (lowOk || cnt >= 2'd2);
        popN = (valid && bus.InstReady) ? (lowOk ? 2'd1 : 2'd2) : 2'd0;
        ack = out && bus.MemAck;
        fill = ack && !drop;
        cntPop = cnt - popN;
        q[0] = popN == 2'd0 ? p[0] : popN == 2'd1 ? p[1] : p[2];
        q[1] = popN == 2'd0 ? p[1] : p[2];
        q[2] = p[2];
        // after a redirect to an odd halfword the low parcel of the first word is skipped
        first = skip ? bus.MemRdata[31:16] : bus.MemRdata[15:0];
        for (int i = 0; i < 3; i++)
            pNext[i] = (!fill || 2'(i) < cntPop) ? q[i] : (2'(i) == cntPop ? first : bus.MemRdata[31:16]);
        cntNext = fill ? cntPop + (skip ? 2'd1 : 2'd2) : cntPop;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            p         <= '{default: '0};
            cnt       <= 2'd0;
            out       <= 1'b0;
            drop      <= 1'b0;
            skip      <= RESET_PC[1];
            instPc    <= RESET_PC;
            fetchAddr <= RESET_PC & ~32'h3;
            memAddr   <= RESET_PC & ~32'h3;
        end else if (bus.Redirect) begin
            // an unacked in-flight read stays on the bus; its data is dropped when it returns
            cnt       <= 2'd0;
            instPc    <= bus.RedirectPc & ~32'h1;
            fetchAddr <= bus.RedirectPc & ~32'h3;
            skip      <= bus.RedirectPc[1];
            drop      <= out && !bus.MemAck;
            out       <= out && !bus.MemAck;
        end else begin
            p      <= pNext;
            cnt    <= cntNext;
            instPc <= instPc + {29'd0, popN, 1'b0};
            if (ack) begin
                out  <= 1'b0;
                drop <= 1'b0;
                if (fill) begin
                    fetchAddr <= fetchAddr + 32'd4;
                    skip      <= 1'b0;
                end
            end else if (!out && cnt <= 2'd1) begin
                out     <= 1'b1;
                memAddr <= fetchAddr;
            end
        end
    end

    assign bus.MemReq         = out;
    assign bus.MemAddr        = memAddr;
    assign bus.InstValid      = valid;
    assign bus.InstCompressed = valid && lowOk;
    assign bus.InstData       = !valid ? 32'h0 : (lowOk ? {16'h0000, p[0]} : {p[1], p[0]});
    assign bus.InstPc         = instPc;
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed vector table, hand sequences and randomized stream check for rvc_fetch_aligner.
module tb_rvc_fetch_aligner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] mem [128];
    int compared = 0;
    int mismatched = 0;

    rvc_fetch_aligner_if ifc();
    rvc_fetch_aligner dut (.Clock(clk), .Reset(rst), .bus(ifc));

    always #5 clk = ~clk;
    assign ifc.MemRdata = mem[ifc.MemAddr[8:2]];

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rpc;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        logic        comp;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic [2:0] ctl, logic [31:0] rpc, logic [1:0] st,
                                logic [31:0] addr, logic [31:0] data, logic comp, logic [31:0] pc);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.st = st; v.addr = addr; v.data = data; v.comp = comp; v.pc = pc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] parcel(logic [31:0] a);
        logic [31:0] w;
        w = mem[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] expInst(logic [31:0] pc);
        logic [15:0] lo;
        lo = parcel(pc);
        return lo[1:0] == 2'b11 ? {parcel(pc + 32'd2), lo} : {16'h0000, lo};
    endfunction

    initial begin
        logic [31:0] expPc, pa, rpc;
        logic pend, redir, accept;
        int accepted;
        // ctl = {MemAck, InstReady, Redirect}; st = {MemReq, InstValid} after the edge
        tbl[0]  = mk(3'b010, 32'h0,   2'b10, 32'h000, 32'h0,         1'b0, 32'h000);
        tbl[1]  = mk(3'b110, 32'h0,   2'b01, 32'h000, 32'h0000_4081, 1'b1, 32'h000);
        tbl[2]  = mk(3'b010, 32'h0,   2'b00, 32'h000, 32'h0,         1'b0, 32'h002);
        tbl[3]  = mk(3'b010, 32'h0,   2'b10, 32'h004, 32'h0,         1'b0, 32'h002);
        tbl[4]  = mk(3'b010, 32'h0,   2'b10, 32'h004, 32'h0,         1'b0, 32'h002);
        tbl[5]  = mk(3'b110, 32'h0,   2'b01, 32'h004, 32'h0010_0093, 1'b0, 32'h002);
        tbl[6]  = mk(3'b000, 32'h0,   2'b01, 32'h004, 32'h0010_0093, 1'b0, 32'h002);
        tbl[7]  = mk(3'b010, 32'h0,   2'b01, 32'h004, 32'h0000_1234, 1'b1, 32'h006);
        tbl[8]  = mk(3'b000, 32'h0,   2'b11, 32'h008, 32'h0000_1234, 1'b1, 32'h006);
        tbl[9]  = mk(3'b001, 32'h102, 2'b10, 32'h008, 32'h0,         1'b0, 32'h102);
        tbl[10] = mk(3'b000, 32'h0,   2'b10, 32'h008, 32'h0,         1'b0, 32'h102);
        tbl[11] = mk(3'b000, 32'h0,   2'b10, 32'h008, 32'h0,         1'b0, 32'h102);
        tbl[12] = mk(3'b100, 32'h0,   2'b00, 32'h008, 32'h0,         1'b0, 32'h102);
        tbl[13] = mk(3'b000, 32'h0,   2'b10, 32'h100, 32'h0,         1'b0, 32'h102);
        tbl[14] = mk(3'b100, 32'h0,   2'b01, 32'h100, 32'h0000_4501, 1'b1, 32'h102);
        tbl[15] = mk(3'b011, 32'h009, 2'b00, 32'h100, 32'h0,         1'b0, 32'h008);
        tbl[16] = mk(3'b010, 32'h0,   2'b10, 32'h008, 32'h0,         1'b0, 32'h008);
        tbl[17] = mk(3'b110, 32'h0,   2'b01, 32'h008, 32'h00A0_0513, 1'b0, 32'h008);
        tbl[18] = mk(3'b010, 32'h0,   2'b00, 32'h008, 32'h0,         1'b0, 32'h00C);
        tbl[19] = mk(3'b110, 32'h0,   2'b10, 32'h00C, 32'h0,         1'b0, 32'h00C);
        tbl[20] = mk(3'b100, 32'h0,   2'b01, 32'h00C, 32'h0000_0001, 1'b1, 32'h00C);
        tbl[21] = mk(3'b010, 32'h0,   2'b01, 32'h00C, 32'h0000_0001, 1'b1, 32'h00E);
        tbl[22] = mk(3'b000, 32'h0,   2'b11, 32'h010, 32'h0000_0001, 1'b1, 32'h00E);
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'h0093_4081; mem[1] = 32'h1234_0010; mem[2] = 32'h00A0_0513;
        mem[3] = 32'h0001_0001; mem[64] = 32'h4501_FFFF;
        ifc.MemAck = 1'b0; ifc.InstReady = 1'b0; ifc.Redirect = 1'b0; ifc.RedirectPc = 32'h0;

        step(); step();
        chk("rst_req", {31'd0, ifc.MemReq}, 32'd0);
        chk("rst_addr", ifc.MemAddr, 32'h0);
        chk("rst_valid", {31'd0, ifc.InstValid}, 32'd0);
        chk("rst_data", ifc.InstData, 32'h0);
        chk("rst_comp", {31'd0, ifc.InstCompressed}, 32'd0);
        chk("rst_pc", ifc.InstPc, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            {ifc.MemAck, ifc.InstReady, ifc.Redirect} = tbl[i].ctl;
            ifc.RedirectPc = tbl[i].rpc;
            step();
            chk($sformatf("row%0d_req", i), {31'd0, ifc.MemReq}, {31'd0, tbl[i].st[1]});
            chk($sformatf("row%0d_valid", i), {31'd0, ifc.InstValid}, {31'd0, tbl[i].st[0]});
            chk($sformatf("row%0d_addr", i), ifc.MemAddr, tbl[i].addr);
            chk($sformatf("row%0d_pc", i), ifc.InstPc, tbl[i].pc);
            if (tbl[i].st[0]) begin
                chk($sformatf("row%0d_data", i), ifc.InstData, tbl[i].data);
                chk($sformatf("row%0d_comp", i), {31'd0, ifc.InstCompressed}, {31'd0, tbl[i].comp});
            end
        end

        // asynchronous reset while a request is pending
        #2 rst = 1'b1;
        #1;
        chk("async_req", {31'd0, ifc.MemReq}, 32'd0);
        chk("async_pc", ifc.InstPc, 32'h0);
        chk("async_valid", {31'd0, ifc.InstValid}, 32'd0);
        mem[0] = 32'h4501_4081; mem[1] = 32'h0010_0093;
        ifc.MemAck = 1'b1; ifc.InstReady = 1'b1;
        @(negedge clk) rst = 1'b0;
        step();
        chk("tp1_req", {31'd0, ifc.MemReq}, 32'd1);
        chk("tp1_addr", ifc.MemAddr, 32'h0);
        step();
        chk("tp1_data0", ifc.InstData, 32'h0000_4081);
        chk("tp1_pc0", ifc.InstPc, 32'h0);
        chk("tp1_valid0", {31'd0, ifc.InstValid}, 32'd1);
        step();
        chk("tp1_data1", ifc.InstData, 32'h0000_4501);
        chk("tp1_pc1", ifc.InstPc, 32'h2);
        ifc.InstReady = 1'b0;
        step();
        chk("bp_issue", {31'd0, ifc.MemReq}, 32'd1);
        chk("bp_addr", ifc.MemAddr, 32'h4);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_req", {31'd0, ifc.MemReq}, 32'd0);
            chk("bp_valid", {31'd0, ifc.InstValid}, 32'd1);
            chk("bp_data", ifc.InstData, 32'h0000_4501);
            chk("bp_pc", ifc.InstPc, 32'h2);
            step();
        end
        ifc.InstReady = 1'b1;
        step();
        chk("bp_next_data", ifc.InstData, 32'h0010_0093);
        chk("bp_next_pc", ifc.InstPc, 32'h4);
        chk("bp_next_comp", {31'd0, ifc.InstCompressed}, 32'd0);

        // randomized stream against the architectural parcel walk
        rst = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        ifc.MemAck = 1'b0; ifc.InstReady = 1'b0; ifc.Redirect = 1'b0;
        step();
        rst = 1'b0;
        expPc = 32'h0;
        accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            ifc.MemAck = ($urandom % 3) != 0;
            ifc.InstReady = ($urandom % 4) != 0;
            ifc.Redirect = ($urandom % 40) == 0;
            rpc = $urandom_range(0, 511);
            ifc.RedirectPc = rpc;
            pend = ifc.MemReq && !ifc.MemAck;
            pa = ifc.MemAddr;
            redir = ifc.Redirect;
            accept = ifc.InstValid && ifc.InstReady && !ifc.Redirect;
            if (accept) begin
                chk("rnd_pc", ifc.InstPc, expPc);
                chk("rnd_data", ifc.InstData, expInst(expPc));
                chk("rnd_comp", {31'd0, ifc.InstCompressed}, {31'd0, expInst(expPc) >> 16 == 32'd0 && parcel(expPc) % 4 != 3});
                expPc = expPc + (parcel(expPc) % 4 == 3 ? 32'd4 : 32'd2);
                accepted++;
            end
            step();
            if (pend) begin
                chk("rnd_req_hold", {31'd0, ifc.MemReq}, 32'd1);
                chk("rnd_addr_hold", ifc.MemAddr, pa);
            end
            chk("rnd_addr_align", {30'd0, ifc.MemAddr[1:0]}, 32'd0);
            if (redir) begin
                expPc = rpc & ~32'h1;
                chk("rnd_redir_pc", ifc.InstPc, expPc);
                chk("rnd_redir_valid", {31'd0, ifc.InstValid}, 32'd0);
            end
        end
        ifc.Redirect = 1'b0;
        chk("rnd_progress", {31'd0, accepted >= 300}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
